// File: rtl/spi_slave.sv
// spi_slave: SPI target endpoint. Oversamples the SPI pins on the system clock
// and turns frames of {R/W, address, data...} into register write strobes and
// read requests. Bursts auto-increment the address while slave select is low.
//
// Read handshake: read_request pulses for one cycle with read_address. The
// fabric answers by raising read_valid with read_data either in that same
// cycle or in the cycle after. If read_valid has not arrived by then, the
// word is shifted out as zeros and read_underrun pulses once. There is no
// backpressure; read_valid outside that two-cycle window is ignored.
module spi_slave #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clock_polarity,
  input  logic                     clock_phase,
  input  logic                     serial_clock,
  input  logic                     slave_select,
  input  logic                     master_out_slave_in,
  output logic                     master_in_slave_out,
  output logic                     miso_enable,
  output logic                     busy,
  output logic                     write_valid,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     read_request,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic                     read_valid,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     frame_error,
  output logic                     read_underrun,
  output logic [2:0]               debug_state
);

  localparam int CNT_MAX = (DATA_WIDTH > ADDRESS_WIDTH) ? DATA_WIDTH : ADDRESS_WIDTH;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMMAND    = 3'd1,
    S_ADDRESS    = 3'd2,
    S_WRITE_DATA = 3'd3,
    S_READ_DATA  = 3'd4
  } state_t;

  state_t                   state_q;
  logic                     sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic                     ss_s1_q, ss_s2_q;
  logic                     mosi_s1_q, mosi_s2_q;
  logic                     armed_q;
  logic                     rw_q;
  logic [CW-1:0]            cnt_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [DATA_WIDTH-1:0]    tx_q;
  logic                     pend_q, pend_age_q;
  logic                     miso_q;
  logic                     write_valid_q, read_request_q, frame_error_q, read_underrun_q;
  logic [ADDRESS_WIDTH-1:0] write_address_q, read_address_q;
  logic [DATA_WIDTH-1:0]    write_data_q;

  logic                     sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                     sample_edge, launch_edge;
  logic                     data_state, word_done, abort_err;
  logic [ADDRESS_WIDTH-1:0] addr_shift_d, addr_inc_d;
  logic [DATA_WIDTH-1:0]    data_shift_d;

  // Edge decode on the synchronized SCLK; the mode bits pick which edge samples.
  assign sclk_rise    = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall    = ~sclk_s2_q & sclk_s3_q;
  assign lead_edge    = clock_polarity ? sclk_fall : sclk_rise;
  assign trail_edge   = clock_polarity ? sclk_rise : sclk_fall;
  assign sample_edge  = clock_phase ? trail_edge : lead_edge;
  assign launch_edge  = clock_phase ? lead_edge : trail_edge;

  assign addr_shift_d = {addr_q[ADDRESS_WIDTH-2:0], mosi_s2_q};
  assign addr_inc_d   = addr_q + ADDRESS_WIDTH'(1);
  assign data_shift_d = {data_q[DATA_WIDTH-2:0], mosi_s2_q};

  // A word is complete only on its last data sample; anything else partway
  // through a word is an abort when SS rises.
  assign data_state = (state_q == S_WRITE_DATA) || (state_q == S_READ_DATA);
  assign word_done  = data_state && sample_edge && (cnt_q == DATA_LAST);
  assign abort_err  = ((state_q == S_COMMAND) && sample_edge) ||
                      (state_q == S_ADDRESS) ||
                      (data_state && !word_done && ((cnt_q != '0) || sample_edge));

  // Two-flop synchronizers for the pins plus a third SCLK stage for edges.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
      ss_s1_q   <= 1'b0; ss_s2_q   <= 1'b0;
      mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= serial_clock;        sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= slave_select;        ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= master_out_slave_in; mosi_s2_q <= mosi_s1_q;
    end
  end

  // Frame decoder FSM with registered strobes, read capture and MISO shifter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      armed_q         <= 1'b0;
      rw_q            <= 1'b0;
      cnt_q           <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      tx_q            <= '0;
      pend_q          <= 1'b0;
      pend_age_q      <= 1'b0;
      miso_q          <= 1'b0;
      write_valid_q   <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      read_request_q  <= 1'b0;
      read_address_q  <= '0;
      frame_error_q   <= 1'b0;
      read_underrun_q <= 1'b0;
    end else begin
      write_valid_q   <= 1'b0;
      read_request_q  <= 1'b0;
      frame_error_q   <= 1'b0;
      read_underrun_q <= 1'b0;
      // Only a high SS seen after reset arms the next frame start.
      if (ss_s2_q) armed_q <= 1'b1;

      // Read data window: the request cycle and the one after it.
      if (pend_q) begin
        if (read_valid) begin
          tx_q   <= read_data;
          pend_q <= 1'b0;
        end else if (pend_age_q) begin
          tx_q            <= '0;
          pend_q          <= 1'b0;
          read_underrun_q <= 1'b1;
        end else begin
          pend_age_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          miso_q <= 1'b0;
          cnt_q  <= '0;
          if (armed_q && !ss_s2_q) state_q <= S_COMMAND;
        end
        S_COMMAND: begin
          miso_q <= 1'b0;
          if (sample_edge) begin
            rw_q    <= mosi_s2_q;
            cnt_q   <= '0;
            state_q <= S_ADDRESS;
          end
        end
        S_ADDRESS: begin
          miso_q <= 1'b0;
          if (sample_edge) begin
            addr_q <= addr_shift_d;
            if (cnt_q == ADDR_LAST) begin
              cnt_q <= '0;
              if (rw_q) begin
                state_q        <= S_READ_DATA;
                read_request_q <= 1'b1;
                read_address_q <= addr_shift_d;
                pend_q         <= 1'b1;
                pend_age_q     <= 1'b0;
              end else begin
                state_q <= S_WRITE_DATA;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_WRITE_DATA, S_READ_DATA: begin
          if (sample_edge) begin
            data_q <= data_shift_d;
            if (cnt_q == DATA_LAST) begin
              cnt_q  <= '0;
              addr_q <= addr_inc_d;
              if (state_q == S_WRITE_DATA) begin
                write_valid_q   <= 1'b1;
                write_address_q <= addr_q;
                write_data_q    <= data_shift_d;
              end else begin
                read_request_q <= 1'b1;
                read_address_q <= addr_inc_d;
                pend_q         <= 1'b1;
                pend_age_q     <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          if (launch_edge) begin
            miso_q <= (state_q == S_READ_DATA) ? tx_q[DATA_WIDTH-1] : 1'b0;
            tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // SS high ends the frame; a word finishing in this same cycle keeps
      // its write strobe, but no further read is requested.
      if ((state_q != S_IDLE) && ss_s2_q) begin
        state_q        <= S_IDLE;
        cnt_q          <= '0;
        pend_q         <= 1'b0;
        read_request_q <= 1'b0;
        miso_q         <= 1'b0;
        frame_error_q  <= abort_err;
      end
    end
  end

  assign busy                = armed_q & ~ss_s2_q;
  assign miso_enable         = armed_q & ~ss_s2_q;
  assign master_in_slave_out = miso_q;
  assign write_valid         = write_valid_q;
  assign write_address       = write_address_q;
  assign write_data          = write_data_q;
  assign read_request        = read_request_q;
  assign read_address        = read_address_q;
  assign frame_error         = frame_error_q;
  assign read_underrun       = read_underrun_q;
  assign debug_state         = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives SPI frames in all four modes and scoreboards the
// parallel write/read side and the MISO data returned to the master.
module tb_spi_slave;

  localparam int DW   = 16;
  localparam int AW   = 15;
  localparam int HALF = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clock_polarity = 1'b0, clock_phase = 1'b0;
  logic          serial_clock = 1'b0, slave_select = 1'b1, master_out_slave_in = 1'b0;
  logic          master_in_slave_out, miso_enable, busy;
  logic          write_valid, read_request, frame_error, read_underrun;
  logic [AW-1:0] write_address, read_address;
  logic [DW-1:0] write_data;
  logic          read_valid = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic [2:0]    debug_state;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cycles = 0;
  int ur_cycles = 0;

  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];

  bit            rsp_en    = 1'b0;
  int            rsp_delay = 0;
  logic [DW-1:0] rsp_data  = '0;

  spi_slave #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .clock_polarity(clock_polarity), .clock_phase(clock_phase),
    .serial_clock(serial_clock), .slave_select(slave_select),
    .master_out_slave_in(master_out_slave_in), .master_in_slave_out(master_in_slave_out),
    .miso_enable(miso_enable), .busy(busy),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .read_request(read_request), .read_address(read_address),
    .read_valid(read_valid), .read_data(read_data),
    .frame_error(frame_error), .read_underrun(read_underrun),
    .debug_state(debug_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (frame_error === 1'b1) fe_cycles++;
      if (read_underrun === 1'b1) ur_cycles++;
      if (write_valid === 1'b1) begin
        check_eq("write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
        if (exp_wr_q.size() != 0)
          check_eq("write_addr_data", {write_address, write_data}, exp_wr_q.pop_front());
      end
      if (read_request === 1'b1) begin
        check_eq("read_expected", 64'(exp_rd_q.size() != 0), 64'd1);
        if (exp_rd_q.size() != 0)
          check_eq("read_addr", read_address, exp_rd_q.pop_front());
      end
    end
  end

  // Fabric read responder
  initial begin
    forever begin
      @(negedge clock);
      if (read_request === 1'b1 && rsp_en) begin
        repeat (rsp_delay) @(negedge clock);
        read_valid = 1'b1;
        read_data  = rsp_data;
        @(negedge clock);
        read_valid = 1'b0;
        read_data  = '0;
      end
    end
  end

  task automatic wait_half();
    repeat (HALF) @(negedge clock);
  endtask

  // Master: nbits of tx sent MSB first; SS rises with the final SCLK edge.
  task automatic spi_xfer(input logic cpol, input logic cpha, input logic [63:0] tx,
                          input int nbits, input bit end_frame, output logic [63:0] rx_o);
    logic [63:0] r;
    r = '0;
    slave_select   = 1'b1;
    clock_polarity = cpol;
    clock_phase    = cpha;
    serial_clock   = cpol;
    wait_half();
    slave_select = 1'b0;
    if (!cpha) master_out_slave_in = tx[nbits-1];
    wait_half();
    check_eq("busy_in_frame", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        r = {r[62:0], master_in_slave_out};
        serial_clock = ~cpol;
        wait_half();
        serial_clock = cpol;
        if (i == nbits - 1) begin
          if (end_frame) slave_select = 1'b1;
        end else begin
          master_out_slave_in = tx[nbits-2-i];
        end
        wait_half();
      end else begin
        serial_clock = ~cpol;
        master_out_slave_in = tx[nbits-1-i];
        wait_half();
        r = {r[62:0], master_in_slave_out};
        serial_clock = cpol;
        if (i == nbits - 1 && end_frame) slave_select = 1'b1;
        wait_half();
      end
    end
    wait_half();
    rx_o = r;
  endtask

  initial begin
    logic [63:0]   rx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset with SS idle
    reset_n = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("reset_outputs",
             {write_valid, read_request, frame_error, read_underrun, busy, miso_enable,
              master_in_slave_out, debug_state, write_address, write_data, read_address}, 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Mode 0 write
    exp_wr_q.push_back({15'h0005, 16'hA5C3});
    spi_xfer(1'b0, 1'b0, {32'd0, 1'b0, 15'h0005, 16'hA5C3}, 32, 1'b1, rx);
    check_eq("mode0_busy_after", busy, 0);

    // Mode 3 read, answered in the request cycle
    rsp_en = 1'b1; rsp_delay = 0; rsp_data = 16'hBEEF;
    exp_rd_q.push_back(15'h1234);
    spi_xfer(1'b1, 1'b1, {32'd0, 1'b1, 15'h1234, 16'h0000}, 32, 1'b1, rx);
    check_eq("mode3_miso", rx[31:0], 32'h0000_BEEF);

    // Burst write across the address wrap
    exp_wr_q.push_back({15'h7FFF, 16'h0001});
    exp_wr_q.push_back({15'h0000, 16'h0002});
    exp_wr_q.push_back({15'h0001, 16'h0003});
    spi_xfer(1'b0, 1'b0, {1'b0, 15'h7FFF, 16'h0001, 16'h0002, 16'h0003}, 64, 1'b1, rx);
    check_eq("burst_fe", 64'(fe_cycles), 0);

    // Abort after 10 data bits, then a clean frame
    spi_xfer(1'b0, 1'b0, {38'd0, 1'b0, 15'h0010, 10'b1010101010}, 26, 1'b1, rx);
    check_eq("abort_fe_pulse", 64'(fe_cycles), 1);
    exp_wr_q.push_back({15'h0011, 16'h1357});
    spi_xfer(1'b0, 1'b0, {32'd0, 1'b0, 15'h0011, 16'h1357}, 32, 1'b1, rx);
    check_eq("after_abort_fe", 64'(fe_cycles), 1);

    // Mode 1 read with no fabric answer
    rsp_en = 1'b0;
    exp_rd_q.push_back(15'h0042);
    spi_xfer(1'b0, 1'b1, {32'd0, 1'b1, 15'h0042, 16'h0000}, 32, 1'b1, rx);
    check_eq("underrun_miso", rx[31:0], 32'd0);
    check_eq("underrun_pulse", 64'(ur_cycles), 1);
    check_eq("underrun_fe", 64'(fe_cycles), 1);

    // Mode 2 write, random address and data
    a = AW'($urandom_range(0, 32767));
    d = DW'($urandom_range(0, 65535));
    exp_wr_q.push_back({a, d});
    spi_xfer(1'b1, 1'b0, {32'd0, 1'b0, a, d}, 32, 1'b1, rx);

    // Mode 0 read answered one cycle late; the next-word prefetch also fires
    a = AW'($urandom_range(0, 32767));
    d = DW'($urandom_range(0, 65535));
    rsp_en = 1'b1; rsp_delay = 1; rsp_data = d;
    exp_rd_q.push_back(a);
    exp_rd_q.push_back(a + AW'(1));
    spi_xfer(1'b0, 1'b0, {32'd0, 1'b1, a, 16'h0000}, 32, 1'b1, rx);
    check_eq("mode0_read_miso", rx[31:0], {16'h0000, d});
    check_eq("late_rsp_no_underrun", 64'(ur_cycles), 1);
    rsp_en = 1'b0;

    // Reset mid-address with SS held low
    spi_xfer(1'b0, 1'b0, {58'd0, 1'b0, 5'b10110}, 6, 1'b0, rx);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("midreset_outputs",
             {write_valid, read_request, frame_error, read_underrun, busy, miso_enable,
              master_in_slave_out, debug_state, write_address, write_data, read_address}, 64'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      serial_clock = ~serial_clock;
      wait_half();
    end
    check_eq("ss_low_after_reset_busy", {busy, miso_enable, debug_state}, 0);
    exp_wr_q.push_back({15'h2A5A, 16'hC0DE});
    spi_xfer(1'b0, 1'b0, {32'd0, 1'b0, 15'h2A5A, 16'hC0DE}, 32, 1'b1, rx);

    // Final scoreboard state
    repeat (10) @(negedge clock);
    check_eq("wr_queue_empty", 64'(exp_wr_q.size()), 0);
    check_eq("rd_queue_empty", 64'(exp_rd_q.size()), 0);
    check_eq("final_fe", 64'(fe_cycles), 1);
    check_eq("final_underrun", 64'(ur_cycles), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
